// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel divided pulse, hold mask,
// enable/stall counters, deferred divisor reprogramming and global phase restart.

module clk_en_gen_ch #(
    parameter int               DIV_W     = 8,
    parameter int               CNT_W     = 64,
    parameter logic [DIV_W-1:0] DIV_RST   = 8'd4,
    parameter logic [DIV_W-1:0] PHASE_RST = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sync_restart,
    input  logic             hold,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_val,
    output logic             en_raw,
    output logic             en,
    output logic             par,
    output logic [CNT_W-1:0] en_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             pending
);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] D_RST_EFF = (DIV_RST == '0) ? ONE : DIV_RST;
    localparam logic [DIV_W-1:0] CNT_RST   = PHASE_RST % D_RST_EFF;

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             raw_q, raw_d;
    logic [CNT_W-1:0] en_cnt_q, en_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [DIV_W-1:0] d_cur, d_new, d_new_eff;
    logic             wrap;

    always_comb begin
        d_cur     = (div_q == '0) ? ONE : div_q;
        wrap      = (cnt_q == d_cur - ONE);
        d_new     = wr_en ? wr_val : (pend_q ? pval_q : div_q);
        d_new_eff = (d_new == '0) ? ONE : d_new;

        div_d    = div_q;
        cnt_d    = cnt_q;
        raw_d    = 1'b0;
        pend_d   = pend_q;
        pval_d   = wr_en ? wr_val : pval_q;
        // Counters track real time: they keep counting through hold and restart.
        en_cnt_d = en_cnt_q + CNT_W'(raw_q);
        stall_d  = stall_q + CNT_W'(raw_q & hold);

        if (sync_restart) begin
            div_d  = d_new;
            cnt_d  = PHASE_RST % d_new_eff;
            pend_d = 1'b0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            raw_d = wrap;
            // A write landing on a wrap edge supersedes the old value and waits a period.
            if (wr_en) begin
                pend_d = 1'b1;
            end else if (wrap && pend_q) begin
                div_d  = pval_q;
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= DIV_RST;
            cnt_q    <= CNT_RST;
            pval_q   <= '0;
            pend_q   <= 1'b0;
            raw_q    <= 1'b0;
            en_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            pval_q   <= pval_d;
            pend_q   <= pend_d;
            raw_q    <= raw_d;
            en_cnt_q <= en_cnt_d;
            stall_q  <= stall_d;
        end
    end

    assign en_raw      = raw_q;
    assign en          = raw_q & ~hold;
    assign par         = en_cnt_q[0];
    assign en_count    = en_cnt_q;
    assign stall_count = stall_q;
    assign pending     = pend_q;
endmodule

module clk_en_gen #(
    parameter int                        NUM_CH     = 3,
    parameter int                        DIV_W      = 8,
    parameter int                        CNT_W      = 64,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT   = {8'd24, 8'd12, 8'd4},
    parameter logic [NUM_CH*DIV_W-1:0]   PHASE_INIT = '0
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       sync_restart,
    input  logic [NUM_CH-1:0]                          ch_hold,
    input  logic                                       div_wr_en,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] div_wr_ch,
    input  logic [DIV_W-1:0]                           div_wr_val,
    output logic [NUM_CH-1:0]                          clk_en_raw,
    output logic [NUM_CH-1:0]                          clk_en,
    output logic [NUM_CH-1:0]                          cyc_par,
    output logic [NUM_CH-1:0][CNT_W-1:0]               en_count,
    output logic [NUM_CH-1:0][CNT_W-1:0]               stall_count,
    output logic [NUM_CH-1:0]                          div_pending
);
    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no lane, so such writes vanish.
        logic wr_hit;
        assign wr_hit = div_wr_en && (div_wr_ch == CH_W'(i));

        clk_en_gen_ch #(
            .DIV_W    (DIV_W),
            .CNT_W    (CNT_W),
            .DIV_RST  (DIV_INIT[i*DIV_W +: DIV_W]),
            .PHASE_RST(PHASE_INIT[i*DIV_W +: DIV_W])
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .sync_restart(sync_restart),
            .hold        (ch_hold[i]),
            .wr_en       (wr_hit),
            .wr_val      (div_wr_val),
            .en_raw      (clk_en_raw[i]),
            .en          (clk_en[i]),
            .par         (cyc_par[i]),
            .en_count    (en_count[i]),
            .stall_count (stall_count[i]),
            .pending     (div_pending[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: default instance plus a phase/short-counter
// instance; edge N is the N-th rising edge after reset release.

module tb_clk_en_gen;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic             sync_restart, div_wr_en;
    logic [2:0]       ch_hold;
    logic [1:0]       div_wr_ch;
    logic [7:0]       div_wr_val;
    logic [2:0]       clk_en_raw, clk_en, cyc_par, div_pending;
    logic [2:0][63:0] en_count, stall_count;

    logic             p_sync_restart, p_div_wr_en;
    logic [2:0]       p_ch_hold;
    logic [1:0]       p_div_wr_ch;
    logic [7:0]       p_div_wr_val;
    logic [2:0]       p_clk_en_raw, p_clk_en, p_cyc_par, p_div_pending;
    logic [2:0][3:0]  p_en_count, p_stall_count;

    clk_en_gen dut (
        .clock(clock), .reset_n(reset_n), .sync_restart(sync_restart),
        .ch_hold(ch_hold), .div_wr_en(div_wr_en), .div_wr_ch(div_wr_ch),
        .div_wr_val(div_wr_val), .clk_en_raw(clk_en_raw), .clk_en(clk_en),
        .cyc_par(cyc_par), .en_count(en_count), .stall_count(stall_count),
        .div_pending(div_pending)
    );

    clk_en_gen #(
        .CNT_W(4),
        .DIV_INIT({8'd1, 8'd12, 8'd4}),
        .PHASE_INIT({8'd0, 8'd0, 8'd2})
    ) dut_p (
        .clock(clock), .reset_n(reset_n), .sync_restart(p_sync_restart),
        .ch_hold(p_ch_hold), .div_wr_en(p_div_wr_en), .div_wr_ch(p_div_wr_ch),
        .div_wr_val(p_div_wr_val), .clk_en_raw(p_clk_en_raw), .clk_en(p_clk_en),
        .cyc_par(p_cyc_par), .en_count(p_en_count), .stall_count(p_stall_count),
        .div_pending(p_div_pending)
    );

    int n_chk = 0;
    int n_fail = 0;
    int edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) begin
            @(posedge clock);
            #1;
            edge_n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sync_restart = 1'b0; ch_hold = '0; div_wr_en = 1'b0;
        div_wr_ch = '0; div_wr_val = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_raw", 64'(clk_en_raw), 64'd0);
        chk("rst_cnt", en_count[0] | en_count[1] | en_count[2], 64'd0);
        chk("rst_stall", stall_count[0] | stall_count[1] | stall_count[2], 64'd0);
        chk("rst_pend", 64'(div_pending), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        p_sync_restart = 1'b0; p_ch_hold = '0; p_div_wr_en = 1'b0;
        p_div_wr_ch = '0; p_div_wr_val = '0;

        // A: free-running dividers, ch1 held over edges 10..40
        do_reset();
        chk("p_rst_cnt", 64'(p_en_count), 64'd0);
        run_to(1);
        chk("p_ch0_e1", 64'(p_clk_en[0]), 64'd0);
        chk("p_ch2_e1", 64'(p_clk_en[2]), 64'd1);
        run_to(2);
        chk("p_ch0_e2", 64'(p_clk_en[0]), 64'd1);
        run_to(3);
        chk("a_e3", 64'(clk_en), 64'b000);
        run_to(4);
        chk("a_e4", 64'(clk_en), 64'b001);
        run_to(5);
        chk("a_e5", 64'(clk_en), 64'b000);
        chk("a_par_e5", 64'(cyc_par), 64'b001);
        chk("p_cnt2_e5", 64'(p_en_count[2]), 64'd4);
        run_to(6);
        chk("p_ch0_e6", 64'(p_clk_en[0]), 64'd1);
        chk("p_cnt2_e6", 64'(p_en_count[2]), 64'd5);
        run_to(8);
        chk("a_e8", 64'(clk_en), 64'b001);
        run_to(9);
        chk("p_ch0_e9", 64'(p_clk_en[0]), 64'd0);
        ch_hold = 3'b010;
        run_to(10);
        chk("p_ch0_e10", 64'(p_clk_en[0]), 64'd1);
        run_to(12);
        chk("a_e12_en", 64'(clk_en), 64'b001);
        chk("a_e12_raw", 64'(clk_en_raw), 64'b011);
        run_to(24);
        chk("a_e24_en", 64'(clk_en), 64'b101);
        chk("a_e24_raw", 64'(clk_en_raw), 64'b111);
        run_to(36);
        chk("a_e36_en", 64'(clk_en), 64'b001);
        chk("a_e36_raw", 64'(clk_en_raw), 64'b011);
        run_to(40);
        ch_hold = 3'b000;
        run_to(41);
        chk("a_stall1", stall_count[1], 64'd3);
        chk("a_cnt1_e41", en_count[1], 64'd3);
        run_to(48);
        chk("a_e48_en", 64'(clk_en), 64'b111);
        // pulses registered on edge 48 are counted on edge 49
        run_to(49);
        chk("a_cnt0", en_count[0], 64'd12);
        chk("a_cnt1", en_count[1], 64'd4);
        chk("a_cnt2", en_count[2], 64'd2);
        chk("a_par", 64'(cyc_par), 64'b000);
        chk("a_stall1_e49", stall_count[1], 64'd3);
        run_to(62);
        chk("p_cnt0_e62", 64'(p_en_count[0]), 64'd15);
        chk("p_par_e62", 64'(p_cyc_par[0]), 64'd1);
        run_to(63);
        chk("p_cnt0_wrap", 64'(p_en_count[0]), 64'd0);
        chk("p_cnt2_e63", 64'(p_en_count[2]), 64'd14);

        // B: invalid-channel write, then ch0 -> 6 written at edge 5
        do_reset();
        run_to(1);
        div_wr_en = 1'b1; div_wr_ch = 2'd3; div_wr_val = 8'd1;
        run_to(2);
        div_wr_en = 1'b0;
        chk("b_badch_pend", 64'(div_pending), 64'd0);
        run_to(4);
        chk("b_e4", 64'(clk_en), 64'b001);
        div_wr_en = 1'b1; div_wr_ch = 2'd0; div_wr_val = 8'd6;
        run_to(5);
        div_wr_en = 1'b0;
        chk("b_pend_e5", 64'(div_pending), 64'b001);
        run_to(7);
        chk("b_pend_e7", 64'(div_pending), 64'b001);
        run_to(8);
        chk("b_e8", 64'(clk_en), 64'b001);
        chk("b_pend_e8", 64'(div_pending), 64'b000);
        run_to(12);
        chk("b_e12", 64'(clk_en), 64'b010);
        run_to(14);
        chk("b_e14", 64'(clk_en), 64'b001);
        run_to(20);
        chk("b_e20", 64'(clk_en), 64'b001);
        run_to(24);
        chk("b_e24", 64'(clk_en), 64'b110);

        // C: 6 at edge 5 overwritten by 2 at edge 6
        do_reset();
        run_to(4);
        div_wr_en = 1'b1; div_wr_ch = 2'd0; div_wr_val = 8'd6;
        run_to(5);
        div_wr_val = 8'd2;
        run_to(6);
        div_wr_en = 1'b0;
        run_to(8);
        chk("c_e8", 64'(clk_en[0]), 64'd1);
        run_to(9);
        chk("c_e9", 64'(clk_en[0]), 64'd0);
        run_to(10);
        chk("c_e10", 64'(clk_en[0]), 64'd1);
        run_to(11);
        chk("c_e11", 64'(clk_en[0]), 64'd0);
        run_to(12);
        chk("c_e12", 64'(clk_en[0]), 64'd1);

        // D: sync_restart at edge 17, deferred ch1 write, async reset mid-cycle
        do_reset();
        run_to(16);
        sync_restart = 1'b1;
        run_to(17);
        sync_restart = 1'b0;
        chk("d_raw_e17", 64'(clk_en_raw), 64'd0);
        chk("d_cnt1_kept", en_count[1], 64'd1);
        chk("d_cnt2_kept", en_count[2], 64'd0);
        div_wr_en = 1'b1; div_wr_ch = 2'd1; div_wr_val = 8'd9;
        run_to(18);
        div_wr_en = 1'b0;
        chk("d_pend_e18", 64'(div_pending), 64'b010);
        run_to(20);
        chk("d_e20", 64'(clk_en), 64'b000);
        run_to(21);
        chk("d_e21", 64'(clk_en), 64'b001);
        run_to(29);
        chk("d_e29", 64'(clk_en), 64'b011);
        chk("d_pend_e29", 64'(div_pending), 64'b000);
        run_to(38);
        chk("d_e38", 64'(clk_en), 64'b010);
        run_to(40);
        chk("d_e40", 64'(clk_en), 64'b000);
        run_to(41);
        chk("d_e41", 64'(clk_en), 64'b101);
        div_wr_en = 1'b1; div_wr_ch = 2'd0; div_wr_val = 8'd7;
        run_to(42);
        div_wr_en = 1'b0;
        chk("d_pend_e42", 64'(div_pending), 64'b001);
        #2;
        reset_n = 1'b0;
        #1;
        chk("d_arst_cnt", en_count[0] | en_count[1] | en_count[2], 64'd0);
        chk("d_arst_pend", 64'(div_pending), 64'd0);
        chk("d_arst_raw", 64'(clk_en_raw), 64'd0);
        chk("d_arst_p_cnt", 64'(p_en_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel clock-enable generator.
- Replaces the fixed per-domain divide-by-N enable blocks and ad-hoc cycle counters in the full-system integration.
- From one master clock, produces N divided enables (e.g. PPU /4, CPU /12, APU /24), each with:
  - a per-channel hold mask (CPU suspend during OAM DMA),
  - a 64-bit enable counter and a parity bit,
  - a stall counter,
  - runtime divisor reprogramming,
  - a global phase-restart.

Parameters:
- NUM_CH, 3: number of enable channels.
- DIV_W, 8: divisor width.
- CNT_W, 64: enable/stall counter width.
- DIV_INIT, {8'd24, 8'd12, 8'd4}: packed NUM_CH×DIV_W reset divisors; channel 0 is in the LSBs.
- PHASE_INIT, '0: packed NUM_CH×DIV_W reset/restart phase offset per channel.

Ports:
- clock  in  1  master clock.
- reset_n  in  1  asynchronous active-low reset.
- sync_restart  in  1  realign all channel phases.
- ch_hold  in  NUM_CH  per-channel enable mask (1 = suspend).
- div_wr_en  in  1  divisor write strobe.
- div_wr_ch  in  $clog2(NUM_CH)  target channel.
- div_wr_val  in  DIV_W  new divisor.
- clk_en_raw  out  NUM_CH  unmasked divided enable.
- clk_en  out  NUM_CH  clk_en_raw & ~ch_hold (combinational mask of the registered raw enable).
- cyc_par  out  NUM_CH  bit 0 of each enable counter.
- en_count  out  NUM_CH×CNT_W  raw enables seen per channel.
- stall_count  out  NUM_CH×CNT_W  enables suppressed by hold.
- div_pending  out  NUM_CH  divisor write waiting to take effect.

Behaviour:
- Clock and reset: one clock domain, `clock`. Reset is asynchronous, active-low, on `reset_n`.
- Reset state:
  - div_cnt[i] = PHASE_INIT[i] mod div[i]; div[i] = DIV_INIT[i].
  - clk_en_raw = 0; en_count = 0; stall_count = 0; div_pending = 0; pending values = 0.
- Effective divisor: d = max(div[i], 1). Divisor 0 or 1 means the enable is high every cycle after the first edge.
- Per-channel divider, each edge:
  - div_cnt <= (div_cnt == d-1) ? 0 : div_cnt+1
  - clk_en_raw[i] <= (div_cnt == d-1)
  - Result: one-cycle pulse, period d.
  - With PHASE 0 and d=4, the first pulse is registered on edge 4 (visible in the cycle after edge 4), then after edges 8, 12, …
- Hold:
  - The divider keeps running under ch_hold, so phase is preserved and releasing hold never causes a short or long period.
  - clk_en[i] is low while held.
  - en_count still increments on raw pulses, so parity and timestamps track real time.
  - stall_count increments on edges where clk_en_raw[i] & ch_hold[i].
- Counters: en_count[i] increments on each edge where clk_en_raw[i] = 1. It wraps modulo 2^CNT_W; same for stall_count.
- Divisor write:
  - On div_wr_en with div_wr_ch < NUM_CH: pending[ch] <= div_wr_val; div_pending[ch] <= 1.
  - div_wr_ch ≥ NUM_CH: write ignored.
  - The pending value is applied on the edge where that channel's div_cnt wraps to 0: div <= pending, div_pending <= 0.
  - A second write before application overwrites the pending value.
  - A write on the same edge as a wrap is not applied by that wrap; it waits for the next wrap.
- sync_restart (synchronous, single-cycle, priority over normal counting):
  - All div_cnt <= PHASE_INIT mod d_new, where d_new = pending value if div_pending, else the current divisor.
  - Pending divisors are applied; div_pending cleared; clk_en_raw <= 0.
  - en_count and stall_count are unchanged.
  - A div_wr_en on the same edge as sync_restart takes effect immediately for that channel.
- Asynchronous reset mid-operation returns to the reset state regardless of pending writes.

Test Plan:
- Reset, default params, no hold → clk_en[0] pulses after edges 4, 8, 12; clk_en[1] after edges 12, 24; clk_en[2] after edges 24, 48. After 48 edges: en_count = {2, 4, 12}, cyc_par = {0, 0, 0}.
- Assert ch_hold[1] for edges 10–40 → clk_en[1] low throughout; clk_en_raw[1] still pulses at 12, 24, 36; stall_count[1] = 3, en_count[1] = 3; after release the next clk_en[1] pulse is at edge 48.
- Write ch0 divisor 6 at edge 5 → div_pending[0] = 1 until the wrap at edge 8; pulses at 8, then 14, 20.
- Write ch0 divisor 6 at edge 5, then 2 at edge 6 → pulses at 8, 10, 12.
- div_wr_ch = 3 (NUM_CH = 3) → no state change.
- PHASE_INIT ch0 = 2, d = 4 → first pulse after edge 2, then 6, 10.
- sync_restart at edge 17 → all channels realign as from reset; en_count values retained; next ch2 pulse at edge 41.
- Divisor 1 on ch2 → clk_en[2] high every cycle; en_count[2] increments by 1 per edge.
- CNT_W = 4 instance: after 16 ch0 pulses, en_count[0] = 0.
- reset_n low mid-count → all outputs return to reset values asynchronously.
